// File: rtl/transpose_row_sequencer_pkg.sv
// transpose_row_sequencer_pkg: shared sizes, row/control types and the XOR-skew control helper.
// Contents: DATA_WIDTH/NUM_INPUTS/FIFO_DEPTH_DEF sizes, NUM_STAGES/NUM_SWITCHES derivations,
//           row_t (one matrix row), ctrl_t (per-stage switch controls), idx_t (row index),
//           ctrl_for_row() which broadcasts each row-index bit across one network stage.
package transpose_row_sequencer_pkg;
   localparam int DATA_WIDTH = 64;
   localparam int NUM_INPUTS = 16;
   localparam int FIFO_DEPTH_DEF = 8;
   localparam int NUM_STAGES = $clog2(NUM_INPUTS);
   localparam int NUM_SWITCHES = NUM_INPUTS / 2;
   typedef logic [0:NUM_INPUTS-1][DATA_WIDTH-1:0] row_t;
   typedef logic [0:NUM_STAGES-1][NUM_SWITCHES-1:0] ctrl_t;
   typedef logic [NUM_STAGES-1:0] idx_t;
   // Stage i swaps every pair exactly when bit i of the row index is set, giving out[j] = in[j ^ idx].
   function automatic ctrl_t ctrl_for_row(idx_t r);
      ctrl_t c;
      for (int i = 0; i < NUM_STAGES; i++) c[i] = {NUM_SWITCHES{r[i]}};
      return c;
   endfunction
endpackage

// File: rtl/transpose_row_sequencer_if.sv
// transpose_row_sequencer_if: bundles the upstream, network and downstream signals of the sequencer.
// Ports: in_val/in_rdy/in_row (upstream rows), net_in_val/net_elements/net_ctrl_arr (to network),
//        net_out_val/net_out_elements (from network), out_val/out_rdy/out_row/out_row_idx/out_last
//        (downstream rows), err (sticky protocol flag).
// slave is the sequencer side, master is the environment side.
interface transpose_row_sequencer_if;
   import transpose_row_sequencer_pkg::*;
   logic in_val, in_rdy;
   row_t in_row;
   logic net_in_val;
   row_t net_elements;
   ctrl_t net_ctrl_arr;
   logic net_out_val;
   row_t net_out_elements;
   logic out_val, out_rdy;
   row_t out_row;
   idx_t out_row_idx;
   logic out_last, err;
   modport slave (
      input in_val, in_row, net_out_val, net_out_elements, out_rdy,
      output in_rdy, net_in_val, net_elements, net_ctrl_arr, out_val, out_row, out_row_idx, out_last, err
   );
   modport master (
      output in_val, in_row, net_out_val, net_out_elements, out_rdy,
      input in_rdy, net_in_val, net_elements, net_ctrl_arr, out_val, out_row, out_row_idx, out_last, err
   );
endinterface

// File: rtl/transpose_row_sequencer_row_fifo.sv
// transpose_row_sequencer_row_fifo: synchronous FIFO with a registered head word.
// Ports: clk, rst (sync active-high), i_push/i_data (write), i_pop (read, ignored when empty),
//        o_data (head word, holds last value when empty), o_full, o_empty.
// A push into an empty FIFO becomes visible on o_data the following cycle; a pop frees space
// in the same cycle, so a push into a full FIFO is taken when it coincides with a pop.
module transpose_row_sequencer_row_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_q;
   logic [PW-1:0] r_rd, r_wr, w_rd_n;
   logic [CW-1:0] r_cnt, w_rem;
   logic w_pop, w_push;
   function automatic logic [PW-1:0] inc(logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction
   assign o_empty = r_cnt == '0;
   assign o_full = r_cnt == CW'(DEPTH);
   assign w_pop = i_pop && !o_empty;
   assign w_push = i_push && (!o_full || w_pop);
   assign w_rd_n = w_pop ? inc(r_rd) : r_rd;
   assign w_rem = r_cnt - CW'(w_pop);
   assign o_data = r_q;
   always_ff @(posedge clk) if (w_push) r_mem[r_wr] <= i_data;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd <= '0;
         r_wr <= '0;
         r_cnt <= '0;
         r_q <= '0;
      end else begin
         r_rd <= w_rd_n;
         if (w_push) r_wr <= inc(r_wr);
         r_cnt <= w_rem + CW'(w_push);
         // Next head comes from storage if anything remains after the pop, else straight from the push.
         r_q <= (w_rem != '0) ? r_mem[w_rd_n] : w_push ? i_data : r_q;
      end
   end
endmodule

// File: rtl/transpose_row_sequencer.sv
// transpose_row_sequencer: feeds rows into the transpose butterfly network and buffers its results.
// Ports: clk, rst (sync active-high), io_bus (slave modport): upstream row handshake,
//        issue register to the network (data + XOR-skew controls), network capture,
//        downstream row handshake with row index / last flag, sticky err.
// Credits cover the FIFO plus every row in flight, because the network cannot be stalled.
module transpose_row_sequencer
   import transpose_row_sequencer_pkg::*;
#(
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input logic clk,
   input logic rst,
   transpose_row_sequencer_if.slave io_bus
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int FW = $bits(row_t) + NUM_STAGES;
   logic [CW-1:0] r_credits;
   idx_t r_row_cnt, r_issue_idx;
   logic r_net_in_val, r_err;
   row_t r_net_elements;
   ctrl_t r_net_ctrl;
   logic [NUM_STAGES-1:0] r_tag_v;
   idx_t r_tag_idx [NUM_STAGES];
   logic w_rdy, w_out_val, w_accept, w_pop, w_push, w_empty, w_full;
   logic [FW-1:0] w_q;
   assign w_rdy = r_credits != '0;
   assign w_out_val = !w_empty;
   assign w_accept = io_bus.in_val && w_rdy;
   assign w_pop = w_out_val && io_bus.out_rdy;
   // Only rows with a live tag are captured, so stray network output never reaches the FIFO.
   assign w_push = io_bus.net_out_val && r_tag_v[NUM_STAGES-1];
   assign io_bus.in_rdy = w_rdy;
   assign io_bus.net_in_val = r_net_in_val;
   assign io_bus.net_elements = r_net_elements;
   assign io_bus.net_ctrl_arr = r_net_ctrl;
   assign io_bus.out_val = w_out_val;
   assign io_bus.out_row = w_q[FW-1:NUM_STAGES];
   assign io_bus.out_row_idx = w_q[NUM_STAGES-1:0];
   assign io_bus.out_last = w_q[NUM_STAGES-1:0] == idx_t'(NUM_INPUTS - 1);
   assign io_bus.err = r_err;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_credits <= CW'(FIFO_DEPTH);
         r_row_cnt <= '0;
         r_issue_idx <= '0;
         r_net_in_val <= 1'b0;
         r_net_elements <= '0;
         r_net_ctrl <= '0;
         r_tag_v <= '0;
         for (int i = 0; i < NUM_STAGES; i++) r_tag_idx[i] <= '0;
         r_err <= 1'b0;
      end else begin
         r_net_in_val <= w_accept;
         if (w_accept) begin
            r_net_elements <= io_bus.in_row;
            r_net_ctrl <= ctrl_for_row(r_row_cnt);
            r_issue_idx <= r_row_cnt;
            r_row_cnt <= r_row_cnt + 1'b1;
         end
         r_credits <= r_credits - CW'(w_accept) + CW'(w_pop);
         // Tag pipe has the network's latency so its tail lines up with net_out_val.
         r_tag_v[0] <= r_net_in_val;
         r_tag_idx[0] <= r_issue_idx;
         for (int i = 1; i < NUM_STAGES; i++) begin
            r_tag_v[i] <= r_tag_v[i-1];
            r_tag_idx[i] <= r_tag_idx[i-1];
         end
         r_err <= r_err | (io_bus.net_out_val != r_tag_v[NUM_STAGES-1]) | (w_push && w_full && !w_pop);
      end
   end
   transpose_row_sequencer_row_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .rst(rst),
      .i_push(w_push),
      .i_data({io_bus.net_out_elements, r_tag_idx[NUM_STAGES-1]}),
      .i_pop(w_pop),
      .o_data(w_q),
      .o_full(w_full),
      .o_empty(w_empty)
   );
endmodule
